// File: rtl/avl_model_pkg.sv
// Shared types and constants for the Avalon RAM simulation model.
//   stall_mode_e     : selects the request_ready back-pressure scheme
//   AVL_LFSR_TAPS    : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   MAX_READ_LATENCY : deepest read pipeline the model supports
//   lfsr_step        : one right-shift step of the Galois LFSR
package avl_model_pkg;

    typedef enum logic [1:0] {
        STALL_NONE     = 2'd0,
        STALL_PERIODIC = 2'd1,
        STALL_LFSR     = 2'd2
    } stall_mode_e;

    localparam logic [15:0] AVL_LFSR_TAPS    = 16'hB400;
    localparam int          MAX_READ_LATENCY = 8;

    // The bit shifted out of the bottom decides whether the taps are folded in.
    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        return state[0] ? ((state >> 1) ^ AVL_LFSR_TAPS) : (state >> 1);
    endfunction

endpackage

// File: rtl/i_avl_bus.sv
// Avalon word-addressed memory bus between a master and the RAM model.
//   address/byte_en/write/write_data/read : master -> slave request
//   read_data/read_data_valid             : slave -> master read response
//   request_ready                         : slave -> master back-pressure
interface i_avl_bus;

    logic [31:0] address;
    logic [3:0]  byte_en;
    logic        write;
    logic [31:0] write_data;
    logic        read;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic        request_ready;

    modport master (
        output address, byte_en, write, write_data, read,
        input  read_data, read_data_valid, request_ready
    );

    modport slave (
        input  address, byte_en, write, write_data, read,
        output read_data, read_data_valid, request_ready
    );

endinterface

// File: rtl/avl_stall_gen.sv
// Generates the registered request_ready back-pressure for the RAM model.
//   clk   : clock
//   rest  : asynchronous active-low reset
//   ready : registered ready, low throughout reset in every mode
// ready during the k-th cycle after reset release reflects the stall state
// for step k (cnt = k mod period, or the LFSR after k steps from the seed).
module avl_stall_gen
    import avl_model_pkg::*;
#(
    parameter int          STALL_MODE   = 0,
    parameter int          STALL_PERIOD = 8,
    parameter int          STALL_LEN    = 2,
    parameter int          STALL_THRESH = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic clk,
    input  logic rest,
    output logic ready
);

    localparam stall_mode_e MODE = stall_mode_e'(STALL_MODE);
    localparam int          CW   = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic          ready_next;

    // Decide the ready value for the current stall state and advance that
    // state by one step; the register below makes ready appear one cycle
    // later so it never depends on anything combinationally.
    always_comb begin
        cnt_next   = cnt;
        lfsr_next  = lfsr;
        ready_next = 1'b1;
        case (MODE)
            STALL_PERIODIC: begin
                ready_next = (int'(cnt) < (STALL_PERIOD - STALL_LEN));
                cnt_next   = (int'(cnt) == STALL_PERIOD - 1) ? '0 : cnt + CW'(1);
            end
            STALL_LFSR: begin
                ready_next = !({1'b0, lfsr[3:0]} < 5'(STALL_THRESH));
                lfsr_next  = lfsr_step(lfsr);
            end
            default: begin
                ready_next = 1'b1;
            end
        endcase
    end

    // Stall state register; reset parks the counter at zero and the LFSR at
    // its seed so the pattern after release is fully repeatable.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            cnt   <= '0;
            lfsr  <= LFSR_SEED;
            ready <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            lfsr  <= lfsr_next;
            ready <= ready_next;
        end
    end

endmodule

// File: rtl/avl_ram_model.sv
// Word-addressed Avalon RAM slave for simulation benches with pipelined
// read latency and configurable request_ready back-pressure.
//   clk    : clock
//   rest   : asynchronous active-low reset (memory contents are kept)
//   avl_m0 : i_avl_bus slave port (address, byte_en, write, write_data,
//            read, read_data, read_data_valid, request_ready)
// Word index is address[AW+1:2]; higher bits alias and address[1:0] is ignored.
module avl_ram_model
    import avl_model_pkg::*;
#(
    parameter int          SIZE         = 32*1024,
    parameter int          READ_LATENCY = 1,
    parameter int          STALL_MODE   = 0,
    parameter int          STALL_PERIOD = 8,
    parameter int          STALL_LEN    = 2,
    parameter int          STALL_THRESH = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter string       INIT_FILE    = "file/ram_data_01.txt"
) (
    input  logic    clk,
    input  logic    rest,
    i_avl_bus.slave avl_m0
);

    localparam int AW    = $clog2(SIZE) + 8;
    localparam int DEPTH = SIZE * 256;

    if (SIZE < 1 || AW > 29) begin : g_bad_size
        $fatal(1, "avl_ram_model: SIZE %0d unsupported", SIZE);
    end
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $fatal(1, "avl_ram_model: READ_LATENCY %0d outside 1..%0d", READ_LATENCY, MAX_READ_LATENCY);
    end
    if (STALL_MODE < 0 || STALL_MODE > 2) begin : g_bad_mode
        $fatal(1, "avl_ram_model: STALL_MODE %0d unknown", STALL_MODE);
    end
    if (STALL_MODE == 1 && (STALL_PERIOD < 2 || STALL_LEN < 0 || STALL_LEN >= STALL_PERIOD)) begin : g_bad_period
        $fatal(1, "avl_ram_model: STALL_PERIOD %0d / STALL_LEN %0d illegal", STALL_PERIOD, STALL_LEN);
    end
    if (STALL_MODE == 2 && (STALL_THRESH < 0 || STALL_THRESH > 16 || LFSR_SEED == 16'h0)) begin : g_bad_lfsr
        $fatal(1, "avl_ram_model: STALL_THRESH %0d / LFSR_SEED %h illegal", STALL_THRESH, LFSR_SEED);
    end

    logic [31:0]                   mem [DEPTH];
    logic [AW-1:0]                 word_idx;
    logic [31:0]                   merged_word;
    logic                          stall_ready;
    logic                          accept_wr;
    logic                          accept_rd;
    logic [READ_LATENCY-1:0]       pipe_valid;
    logic [READ_LATENCY-1:0][31:0] pipe_data;
    logic                          unused_addr_bits;

    assign word_idx         = avl_m0.address[AW+1:2];
    assign unused_addr_bits = ^{avl_m0.address[31:AW+2], avl_m0.address[1:0]};

    // A simultaneous read is dropped in favour of the write.
    assign accept_wr = stall_ready && avl_m0.write;
    assign accept_rd = stall_ready && avl_m0.read && !avl_m0.write;

    avl_stall_gen #(
        .STALL_MODE  (STALL_MODE),
        .STALL_PERIOD(STALL_PERIOD),
        .STALL_LEN   (STALL_LEN),
        .STALL_THRESH(STALL_THRESH),
        .LFSR_SEED   (LFSR_SEED)
    ) u_stall (
        .clk  (clk),
        .rest (rest),
        .ready(stall_ready)
    );

    // Build the post-write word by overlaying the enabled byte lanes on the
    // current contents, so the array itself is written as whole words.
    always_comb begin
        merged_word = mem[word_idx];
        for (int b = 0; b < 4; b++) begin
            if (avl_m0.byte_en[b]) begin
                merged_word[8*b +: 8] = avl_m0.write_data[8*b +: 8];
            end
        end
    end

    // Commit accepted writes and flag masters that raise read and write
    // together, since that read is silently lost.
    always_ff @(posedge clk) begin
        if (accept_wr) begin
            mem[word_idx] <= merged_word;
            if (avl_m0.read) begin
                $error("avl_ram_model: read and write together at address %h, read dropped", avl_m0.address);
            end
        end
    end

    // Read pipeline: the word is captured at the accept edge so later writes
    // cannot disturb it, then shifts one stage per cycle. Each stage only
    // loads data alongside a valid, so the last stage holds read_data steady
    // between responses. Reset drops every in-flight read.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            pipe_valid <= '0;
            pipe_data  <= '0;
        end else begin
            pipe_valid[0] <= accept_rd;
            if (accept_rd) begin
                pipe_data[0] <= mem[word_idx];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign avl_m0.request_ready   = stall_ready;
    assign avl_m0.read_data       = pipe_data[READ_LATENCY-1];
    assign avl_m0.read_data_valid = pipe_valid[READ_LATENCY-1];

endmodule
